// File: rtl/alu_pkg.sv
// alu_pkg: shared types and helpers for the sequential Z80-style ALU.
//   alu_op_e     - 4-bit opcode encoding presented on the opcode port
//   state_e      - control FSM states (idle / shifting / result held)
//   FLAG_*       - bit positions inside the 8-bit Z80 flag byte
//   parity_even  - 1 when the argument has an even number of set bits
//   is_shift_op  - 1 for the shift/rotate opcodes handled bit-serially
package alu_pkg;

    typedef enum logic [3:0] {
        OpAdd = 4'h0,
        OpAdc = 4'h1,
        OpSub = 4'h2,
        OpSbc = 4'h3,
        OpAnd = 4'h4,
        OpOr  = 4'h5,
        OpXor = 4'h6,
        OpCp  = 4'h7,
        OpInc = 4'h8,
        OpDec = 4'h9,
        OpSll = 4'hA,
        OpSrl = 4'hB,
        OpSla = 4'hC,
        OpSra = 4'hD,
        OpRol = 4'hE,
        OpRor = 4'hF
    } alu_op_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    localparam int unsigned FLAG_S  = 7;
    localparam int unsigned FLAG_Z  = 6;
    localparam int unsigned FLAG_H  = 4;
    localparam int unsigned FLAG_PV = 2;
    localparam int unsigned FLAG_N  = 1;
    localparam int unsigned FLAG_C  = 0;

    // Widest operand the parity helper accepts; callers zero-extend, which
    // leaves parity unchanged.
    localparam int unsigned PARITY_MAX_W = 256;

    function automatic logic parity_even(input logic [PARITY_MAX_W-1:0] v);
        return ~(^v);
    endfunction

    function automatic logic is_shift_op(input alu_op_e op);
        return op inside {OpSll, OpSrl, OpSla, OpSra, OpRol, OpRor};
    endfunction

endpackage

// File: rtl/alu_seq_core.sv
// alu_seq_core: single-cycle combinational part of the ALU.
//   i_op     - operation (alu_op_e)
//   i_a      - operand A
//   i_b      - operand B (ignored by INC/DEC)
//   i_c      - current carry flag: carry-in for ADC/SBC, value kept by
//              INC/DEC and by zero-length shifts/rotates
//   o_result - result of the operation (A for CP and for shift ops)
//   o_flags  - Z80 flag byte S Z 0 H 0 P/V N C
// Shift/rotate opcodes here only cover the zero-length case; the bit-serial
// shifter lives in the top level.
module alu_seq_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  alu_op_e          i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_c,
    output logic [WIDTH-1:0] o_result,
    output logic [7:0]       o_flags
);

    localparam int unsigned MSB = WIDTH - 1;

    logic             w_sub_op;
    logic             w_cin;
    logic [WIDTH-1:0] w_opb;
    logic [WIDTH:0]   w_cin_ext;
    logic [WIDTH:0]   w_sum;
    logic [4:0]       w_half;
    logic             w_ovf;

    // Shared adder/subtractor: bit WIDTH is carry (add) or borrow (sub),
    // w_half[4] is the nibble carry/borrow.
    always_comb begin
        w_sub_op  = i_op inside {OpSub, OpSbc, OpCp, OpDec};
        w_cin     = (i_op inside {OpAdc, OpSbc}) ? i_c : 1'b0;
        w_opb     = (i_op inside {OpInc, OpDec}) ? WIDTH'(1) : i_b;
        w_cin_ext = {{WIDTH{1'b0}}, w_cin};
        if (w_sub_op) begin
            w_sum  = {1'b0, i_a} - {1'b0, w_opb} - w_cin_ext;
            w_half = {1'b0, i_a[3:0]} - {1'b0, w_opb[3:0]} - {4'b0000, w_cin};
            w_ovf  = (i_a[MSB] != w_opb[MSB]) && (w_sum[MSB] != i_a[MSB]);
        end else begin
            w_sum  = {1'b0, i_a} + {1'b0, w_opb} + w_cin_ext;
            w_half = {1'b0, i_a[3:0]} + {1'b0, w_opb[3:0]} + {4'b0000, w_cin};
            w_ovf  = (i_a[MSB] == w_opb[MSB]) && (w_sum[MSB] != i_a[MSB]);
        end
    end

    always_comb begin
        o_result = w_sum[WIDTH-1:0];
        o_flags  = 8'h00;
        case (i_op)
            OpAdd, OpAdc, OpSub, OpSbc, OpCp: begin
                o_flags[FLAG_H]  = w_half[4];
                o_flags[FLAG_PV] = w_ovf;
                o_flags[FLAG_N]  = w_sub_op;
                o_flags[FLAG_C]  = w_sum[WIDTH];
                if (i_op == OpCp) begin
                    o_result = i_a;
                end
            end
            OpAnd: begin
                o_result         = i_a & i_b;
                o_flags[FLAG_H]  = 1'b1;
                o_flags[FLAG_PV] = parity_even(PARITY_MAX_W'(i_a & i_b));
            end
            OpOr: begin
                o_result         = i_a | i_b;
                o_flags[FLAG_PV] = parity_even(PARITY_MAX_W'(i_a | i_b));
            end
            OpXor: begin
                o_result         = i_a ^ i_b;
                o_flags[FLAG_PV] = parity_even(PARITY_MAX_W'(i_a ^ i_b));
            end
            OpInc, OpDec: begin
                o_flags[FLAG_H]  = w_half[4];
                o_flags[FLAG_PV] = w_ovf;
                o_flags[FLAG_N]  = w_sub_op;
                o_flags[FLAG_C]  = i_c;
            end
            default: begin
                // Zero-length shift/rotate: operand passes through, C kept.
                o_result         = i_a;
                o_flags[FLAG_PV] = parity_even(PARITY_MAX_W'(i_a));
                o_flags[FLAG_C]  = i_c;
            end
        endcase
        // CP takes S and Z from the difference, as on the Z80.
        if (i_op == OpCp) begin
            o_flags[FLAG_S] = w_sum[MSB];
            o_flags[FLAG_Z] = (w_sum[WIDTH-1:0] == '0);
        end else begin
            o_flags[FLAG_S] = o_result[MSB];
            o_flags[FLAG_Z] = (o_result == '0);
        end
    end

endmodule

// File: rtl/alu_seq_n.sv
// alu_seq_n: handshaked, registered Z80 datapath ALU.
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid / in_ready - operation request / ALU idle and able to accept
//   opcode, a, b        - operation (alu_op_e), operands; b is the shift amount
//   out_valid/out_ready - result held / consumer takes it
//   result, flags       - registered result and Z80 flags S Z 0 H 0 P/V N C
// WIDTH must be >= 8 and a multiple of 4. Shifts and rotates run one bit per
// cycle; everything else completes in the accept cycle.
module alu_seq_n
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [7:0]       flags
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned MSB   = WIDTH - 1;

    state_e           r_state;
    state_e           w_state_d;
    alu_op_e          r_op;
    logic [WIDTH-1:0] r_sh;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_result;
    logic [7:0]       r_flags;

    alu_op_e          w_op;
    logic             w_accept;
    logic             w_to_shift;
    logic [CNT_W-1:0] w_k;
    logic [WIDTH-1:0] w_core_res;
    logic [7:0]       w_core_flags;
    logic [WIDTH-1:0] w_sh_next;
    logic             w_sh_out;
    logic [7:0]       w_sh_flags;
    logic             w_last;

    assign w_op      = alu_op_e'(opcode);
    assign in_ready  = (r_state == StIdle);
    assign out_valid = (r_state == StDone);
    assign result    = r_result;
    assign flags     = r_flags;
    assign w_accept  = in_valid && in_ready;

    // Rotates wrap the amount; shifts saturate at WIDTH (all bits gone).
    always_comb begin
        if (w_op inside {OpRol, OpRor}) begin
            w_k = CNT_W'(b % WIDTH'(WIDTH));
        end else if (b >= WIDTH'(WIDTH)) begin
            w_k = CNT_W'(WIDTH);
        end else begin
            w_k = CNT_W'(b);
        end
        w_to_shift = is_shift_op(w_op) && (w_k != '0);
    end

    alu_seq_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_op     (w_op),
        .i_a      (a),
        .i_b      (b),
        .i_c      (r_flags[FLAG_C]),
        .o_result (w_core_res),
        .o_flags  (w_core_flags)
    );

    // One-bit shift step of the working value.
    always_comb begin
        w_sh_out  = 1'b0;
        w_sh_next = r_sh;
        case (r_op)
            OpSll, OpSla: begin
                w_sh_out  = r_sh[MSB];
                w_sh_next = {r_sh[MSB-1:0], 1'b0};
            end
            OpSrl: begin
                w_sh_out  = r_sh[0];
                w_sh_next = {1'b0, r_sh[MSB:1]};
            end
            OpSra: begin
                w_sh_out  = r_sh[0];
                w_sh_next = {r_sh[MSB], r_sh[MSB:1]};
            end
            OpRol: begin
                w_sh_out  = r_sh[MSB];
                w_sh_next = {r_sh[MSB-1:0], r_sh[MSB]};
            end
            OpRor: begin
                w_sh_out  = r_sh[0];
                w_sh_next = {r_sh[0], r_sh[MSB:1]};
            end
            default: ;
        endcase
        w_sh_flags          = 8'h00;
        w_sh_flags[FLAG_S]  = w_sh_next[MSB];
        w_sh_flags[FLAG_Z]  = (w_sh_next == '0);
        w_sh_flags[FLAG_PV] = parity_even(PARITY_MAX_W'(w_sh_next));
        w_sh_flags[FLAG_C]  = w_sh_out;
        w_last              = (r_cnt == CNT_W'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_d = w_to_shift ? StShift : StDone;
                end
            end
            StShift: begin
                if (w_last) begin
                    w_state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Result and flags only change on entry to StDone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= OpAdd;
            r_sh     <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_flags  <= 8'h00;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_op  <= w_op;
                        r_sh  <= a;
                        r_cnt <= w_k;
                        if (!w_to_shift) begin
                            r_result <= w_core_res;
                            r_flags  <= w_core_flags;
                        end
                    end
                end
                StShift: begin
                    r_sh  <= w_sh_next;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (w_last) begin
                        r_result <= w_sh_next;
                        r_flags  <= w_sh_flags;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_n.sv
// tb_alu_seq_n: directed scoreboard bench for alu_seq_n (WIDTH = 8).
// The driver pushes hand-computed result/flags/latency on each issued
// operation; a monitor pops and compares on every rising out_valid.
module tb_alu_seq_n;
    import alu_pkg::*;

    typedef struct {
        logic [7:0] res;
        logic [7:0] flg;
        int         lat;
        int         acc_cyc;
        string      name;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] opcode;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic [7:0] flags;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic prev_valid = 1'b0;

    alu_seq_n #(
        .WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    // Monitor: compare on the first cycle of every out_valid pulse.
    always @(negedge clk) begin
        if (out_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: result=0x%0h flags=0x%0h", result, flags);
            end else begin
                mon_e = exp_q.pop_front();
                chk({mon_e.name, "_result"}, int'(result), int'(mon_e.res));
                chk({mon_e.name, "_flags"}, int'(flags), int'(mon_e.flg));
                chk({mon_e.name, "_latency"}, cyc - mon_e.acc_cyc, mon_e.lat);
            end
        end
        prev_valid <= out_valid;
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input alu_op_e op, input logic [7:0] va, input logic [7:0] vb,
                         input logic [7:0] er, input logic [7:0] ef, input int lat,
                         input string nm, input bit push);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_in_ready_before_issue"}, int'(in_ready), 1);
        in_valid = 1'b1;
        opcode   = op;
        a        = va;
        b        = vb;
        if (push) exp_q.push_back('{res: er, flg: ef, lat: lat, acc_cyc: cyc, name: nm});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        opcode    = 4'h0;
        a         = 8'h00;
        b         = 8'h00;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_result", int'(result), 0);
        chk("reset_flags", int'(flags), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Arithmetic, carry chaining through the flag register.
        issue(OpAdd, 8'h7F, 8'h01, 8'h80, 8'h94, 1, "add_7f_01", 1'b1);
        issue(OpInc, 8'hFF, 8'h00, 8'h00, 8'h50, 1, "inc_ff", 1'b1);
        issue(OpSub, 8'h00, 8'h01, 8'hFF, 8'h93, 1, "sub_00_01", 1'b1);
        issue(OpSbc, 8'h10, 8'h00, 8'h0F, 8'h12, 1, "sbc_10_00", 1'b1);

        // Rotates: b mod 8.
        issue(OpRol, 8'h81, 8'd9, 8'h03, 8'h05, 2, "rol_k1", 1'b1);
        issue(OpRol, 8'h81, 8'd8, 8'h81, 8'h85, 1, "rol_k0", 1'b1);

        // SRA saturating at 8 bits, with a stray request mid-shift.
        issue(OpSra, 8'h80, 8'd12, 8'hFF, 8'h85, 9, "sra_k8", 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk("sra_busy_in_ready", int'(in_ready), 0);
            if (i == 2) begin
                in_valid = 1'b1;
                opcode   = OpAdd;
                a        = 8'h01;
                b        = 8'h01;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;

        issue(OpDec, 8'h10, 8'h00, 8'h0F, 8'h13, 1, "dec_10_keep_c", 1'b1);
        issue(OpAdd, 8'h80, 8'h80, 8'h00, 8'h45, 1, "add_80_80", 1'b1);
        issue(OpAdc, 8'h0F, 8'h00, 8'h10, 8'h10, 1, "adc_0f_cin1", 1'b1);
        issue(OpXor, 8'hFF, 8'hFF, 8'h00, 8'h44, 1, "xor_ff_ff", 1'b1);
        issue(OpCp, 8'h20, 8'h10, 8'h20, 8'h02, 1, "cp_20_10", 1'b1);
        issue(OpSrl, 8'h01, 8'd1, 8'h00, 8'h45, 2, "srl_01_1", 1'b1);
        issue(OpSll, 8'h81, 8'd2, 8'h04, 8'h00, 3, "sll_81_2", 1'b1);

        // Backpressure: result held while out_ready is low.
        while (!in_ready) @(negedge clk);
        out_ready = 1'b0;
        issue(OpAnd, 8'hF0, 8'h3C, 8'h30, 8'h14, 1, "and_f0_3c", 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("hold_out_valid", int'(out_valid), 1);
            chk("hold_result", int'(result), 8'h30);
            chk("hold_flags", int'(flags), 8'h14);
            chk("hold_in_ready", int'(in_ready), 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", int'(in_ready), 1);
        chk("release_out_valid", int'(out_valid), 0);

        // Asynchronous reset in the middle of a ROR.
        issue(OpRor, 8'h12, 8'd7, 8'h00, 8'h00, 8, "ror_aborted", 1'b0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", int'(out_valid), 0);
        chk("async_rst_flags", int'(flags), 0);
        chk("async_rst_result", int'(result), 0);
        chk("async_rst_in_ready", int'(in_ready), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("post_rst_out_valid", int'(out_valid), 0);
            chk("post_rst_in_ready", int'(in_ready), 1);
        end

        // Carry cleared by reset: ADC adds nothing extra.
        issue(OpAdc, 8'hFF, 8'h00, 8'hFF, 8'h80, 1, "adc_after_rst", 1'b1);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
